// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1-to-8 demultiplexer.
// Channel count, select width and transfer counter width live here.
package demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 16;

    // One-hot decode of a channel select
    function automatic logic [NUM_CH-1:0] chDecode(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oneHot;
        oneHot      = '0;
        oneHot[sel] = 1'b1;
        return oneHot;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel slot: a valid bit plus a data register.
// A load wins over a drain so a same-cycle refill causes no bubble.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] loadData,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Slot state: load a new word, else drop it once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= loadData;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1x8_buf.sv
// Buffered 1-to-8 demultiplexer with per-channel valid/ready slots.
// Decode, in_ready mux and the accept counter sit at this level.
module demux_1x8_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]        xfer_cnt,
    output logic                    idle
);

    logic              accept;
    logic [NUM_CH-1:0] loadVec;
    logic [NUM_CH-1:0] drainVec;

    // Target slot can take a word if empty or draining this cycle
    always_comb begin
        in_ready = ~out_valid[in_sel] | out_ready[in_sel];
        accept   = in_valid & in_ready;
        loadVec  = accept ? chDecode(in_sel) : '0;
        drainVec = out_valid & out_ready;
        idle     = (out_valid == '0);
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : gSlot
        demux_slot #(
            .WIDTH(WIDTH)
        ) uSlot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (loadVec[k]),
            .drain   (drainVec[k]),
            .loadData(in_data),
            .valid   (out_valid[k]),
            .data    (out_data[k*WIDTH +: WIDTH])
        );
    end

    // Count accepted words, wrapping naturally at the counter width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (accept) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_1x8_buf.sv
// Directed self-checking bench for demux_1x8_buf.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_demux_1x8_buf;

    localparam int WIDTH = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_data;
    logic [2:0]     in_sel;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [255:0]   out_data;
    logic [15:0]    xfer_cnt;
    logic           idle;

    int passCnt = 0;
    int totalCnt = 0;

    demux_1x8_buf #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .xfer_cnt (xfer_cnt),
        .idle     (idle)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    function automatic logic [31:0] chData(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus sequence
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        #3;
        check("rst_valid", 64'(out_valid), 64'h00);
        check("rst_cnt", 64'(xfer_cnt), 64'h0);
        check("rst_idle", 64'(idle), 64'h1);
        check("rst_data5", 64'(chData(5)), 64'h0);

        // Release away from an edge; the next edge accepts the word
        @(negedge clk);
        rst_n     = 1'b1;
        in_sel    = 3'd5;
        in_data   = 32'hDEADBEEF;
        in_valid  = 1'b1;
        out_ready = 8'hFF;
        step();
        in_valid = 1'b0;
        check("first_valid", 64'(out_valid), 64'h20);
        check("first_data5", 64'(chData(5)), 64'hDEADBEEF);
        check("first_cnt", 64'(xfer_cnt), 64'h1);
        check("first_idle", 64'(idle), 64'h0);
        step();
        check("first_drained", 64'(out_valid), 64'h00);

        // Backpressure on channel 2
        out_ready = 8'h00;
        in_sel    = 3'd2;
        in_data   = 32'h11;
        in_valid  = 1'b1;
        #1;
        check("bp_ready_empty", 64'(in_ready), 64'h1);
        step();
        check("bp_valid1", 64'(out_valid), 64'h04);
        check("bp_data1", 64'(chData(2)), 64'h11);
        in_data = 32'h22;
        #1;
        check("bp_ready_full", 64'(in_ready), 64'h0);
        in_valid = 1'b0;
        #1;
        check("bp_ready_novalid", 64'(in_ready), 64'h0);
        in_valid = 1'b1;
        step();
        check("bp_hold_data", 64'(chData(2)), 64'h11);
        check("bp_hold_cnt", 64'(xfer_cnt), 64'h2);
        step();
        check("bp_hold_data2", 64'(chData(2)), 64'h11);
        check("bp_hold_valid", 64'(out_valid), 64'h04);
        out_ready = 8'h04;
        #1;
        check("bp_ready_drain", 64'(in_ready), 64'h1);
        step();
        check("bp_new_data", 64'(chData(2)), 64'h22);
        check("bp_new_valid", 64'(out_valid), 64'h04);
        check("bp_new_cnt", 64'(xfer_cnt), 64'h3);
        in_valid = 1'b0;
        step();
        check("bp_empty", 64'(out_valid), 64'h00);

        // Same-cycle drain and refill on channel 3
        out_ready = 8'h00;
        in_sel    = 3'd3;
        in_data   = 32'h33;
        in_valid  = 1'b1;
        step();
        check("pass_fill", 64'(out_valid), 64'h08);
        out_ready = 8'h08;
        in_data   = 32'hA5;
        #1;
        check("pass_ready", 64'(in_ready), 64'h1);
        step();
        check("pass_valid", 64'(out_valid), 64'h08);
        check("pass_data", 64'(chData(3)), 64'hA5);
        check("pass_cnt", 64'(xfer_cnt), 64'h5);
        in_valid = 1'b0;
        #1;
        check("pass_ready2", 64'(in_ready), 64'h1);
        step();
        check("pass_empty", 64'(out_valid), 64'h00);

        // Fill all eight channels, then drain together
        out_ready = 8'h00;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel  = 3'(i);
            in_data = 32'h100 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        check("all_valid", 64'(out_valid), 64'hFF);
        check("all_idle", 64'(idle), 64'h0);
        check("all_data0", 64'(chData(0)), 64'h100);
        check("all_data7", 64'(chData(7)), 64'h107);
        check("all_cnt", 64'(xfer_cnt), 64'd13);
        check("all_ready", 64'(in_ready), 64'h0);
        out_ready = 8'hFF;
        step();
        check("all_drained", 64'(out_valid), 64'h00);
        check("all_idle2", 64'(idle), 64'h1);
        check("all_stale7", 64'(chData(7)), 64'h107);

        // Mid-operation reset with channels 0..3 full
        out_ready = 8'h00;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel  = 3'(i);
            in_data = 32'h200 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        check("mr_pre_valid", 64'(out_valid), 64'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 64'(out_valid), 64'h00);
        check("mr_cnt", 64'(xfer_cnt), 64'h0);
        check("mr_idle", 64'(idle), 64'h1);
        check("mr_data0", 64'(chData(0)), 64'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 8'hFF;
        step();
        check("mr_post_valid", 64'(out_valid), 64'h00);
        check("mr_post_cnt", 64'(xfer_cnt), 64'h0);

        // Counter wrap: 65535 accepts, then one more
        in_valid  = 1'b1;
        out_ready = 8'hFF;
        for (int i = 0; i < 65535; i++) begin
            in_sel  = 3'(i);
            in_data = 32'(i);
            step();
        end
        check("wrap_max", 64'(xfer_cnt), 64'hFFFF);
        step();
        check("wrap_zero", 64'(xfer_cnt), 64'h0000);
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/demux_1x8_buf.md
DEMUX_1X8_BUF -- requirements
Module: demux_1x8_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream word present.
REQ-005 SHALL have port in_ready  output  1  word accepted this cycle when in_valid is also high.
REQ-006 SHALL have port in_data  input  WIDTH  word to route.
REQ-007 SHALL have port in_sel  input  3  destination channel 0..7.
REQ-008 SHALL have port out_valid  output  8  bit k high means channel k holds a word.
REQ-009 SHALL have port out_ready  input  8  bit k high means the consumer on channel k takes its word.
REQ-010 SHALL have port out_data  output  8*WIDTH  channel k data on bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port xfer_cnt  output  16  count of accepted input words.
REQ-012 SHALL have port idle  output  1  high when out_valid == 8'h00.

Function
REQ-013 SHALL hold one registered slot per channel, consisting of a valid bit and a WIDTH-bit data register.
REQ-014 SHALL drive in_ready combinationally as ~out_valid[in_sel] | out_ready[in_sel].
REQ-015 SHALL, on accept (in_valid & in_ready), load in_data into slot in_sel and set out_valid[in_sel] at the next edge: latency 1 cycle.
REQ-016 SHALL clear out_valid[k] at the next edge when out_valid[k] & out_ready[k] and channel k is not written in the same cycle.
REQ-017 SHALL, on a same-cycle drain and write to channel k, keep out_valid[k] high and load the new word, with no bubble and no loss.
REQ-018 SHALL hold out_data for channel k stable while out_valid[k] is high and out_ready[k] is low.
REQ-019 SHALL leave every slot other than in_sel unchanged by an accept, and SHALL let those channels drain independently in the same cycle.
REQ-020 SHALL leave out_data of an empty slot at its last value; consumers must ignore it.
REQ-021 SHALL increment xfer_cnt by 1 per accept, modulo 2^16, wrapping 16'hFFFF -> 16'h0000.
REQ-022 SHALL make in_ready depend only on in_sel, out_valid and out_ready, never on in_valid.
REQ-023 Upstream SHALL keep in_data and in_sel stable while in_valid is high and in_ready is low; the bench checks this and the RTL need not tolerate violations.

Reset
REQ-024 SHALL, while rst_n is low, force out_valid = 8'h00, all slot data = 0, xfer_cnt = 0 and idle = 1, asynchronously and regardless of clk.
REQ-025 SHALL drop words in flight when reset is asserted mid-operation, with nothing delivered afterwards.
REQ-026 SHALL accept the first word on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL take NUM_CH = 8, SEL_W = 3 and CNT_W = 16 from the shared package demux_pkg.
REQ-028 SHALL instantiate eight copies of sub-module demux_slot: one valid+data register with load, drain and async reset.
REQ-029 SHALL keep the destination decode, in_ready mux and xfer_cnt in the top level.

Verification
REQ-030 The bench SHALL cover: reset, then in_sel=5, in_data=32'hDEADBEEF, in_valid=1, out_ready=8'hFF -> next cycle out_valid=8'h20, out_data[5]=32'hDEADBEEF, xfer_cnt=1.
REQ-031 The bench SHALL cover: out_ready=0, two writes to channel 2 (32'h11, 32'h22) -> first accepted; in_ready=0 on the second until out_ready[2]=1; 32'h11 held stable meanwhile.
REQ-032 The bench SHALL cover: channel 3 full with out_ready[3]=1, new write 32'hA5 to channel 3 in the same cycle -> out_valid[3] stays 1, out_data[3]=32'hA5, in_ready=1 throughout.
REQ-033 The bench SHALL cover: eight back-to-back writes with in_sel=0..7 and out_ready=0 -> out_valid=8'hFF, idle=0; then out_ready=8'hFF -> out_valid=8'h00 and idle=1 one cycle later.
REQ-034 The bench SHALL cover: preload xfer_cnt to 16'hFFFF via 65535 accepts, then one more accept -> xfer_cnt=16'h0000.
REQ-035 The bench SHALL cover: rst_n pulsed low between clock edges with out_valid=8'h0F -> out_valid=0, xfer_cnt=0 immediately, and no spurious delivery after release.
